// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: ready/valid pipeline register with flush and exception sideband.
// Build option PIPE_SKID_EN: 2-entry skid buffer with a registered in_ready.
module pipe_stage_buf #(
   parameter int DATA_W = 134,
   parameter int EXC_W  = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [EXC_W-1:0]  in_exccode,
   input  logic              in_delay,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [EXC_W-1:0]  out_exccode,
   output logic              out_delay,
   output logic              out_exc,
   output logic [1:0]        occupancy
);

   logic              w_acc;
   logic              w_con;
   logic [DATA_W-1:0] r_h_data;
   logic [DATA_W-1:0] w_h_data;
   logic [EXC_W-1:0]  r_h_exc;
   logic [EXC_W-1:0]  w_h_exc;
   logic              r_h_dly;
   logic              w_h_dly;

`ifdef PIPE_SKID_EN
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state;
   logic [DATA_W-1:0] r_s_data;
   logic [DATA_W-1:0] w_s_data;
   logic [EXC_W-1:0]  r_s_exc;
   logic [EXC_W-1:0]  w_s_exc;
   logic              r_s_dly;
   logic              w_s_dly;

   // Ready comes straight from state, so out_ready never reaches in_ready.
   assign in_ready  = (r_state != FULL);
   assign occupancy = (r_state == FULL) ? 2'd2 :
                      (r_state == ONE)  ? 2'd1 : 2'd0;
`else
   typedef enum logic {
      EMPTY = 1'b0,
      ONE   = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state;

   assign in_ready  = (r_state == EMPTY) || out_ready;
   assign occupancy = {1'b0, r_state == ONE};
`endif

   assign out_valid   = (r_state != EMPTY);
   assign w_acc       = in_valid && in_ready;
   assign w_con       = out_valid && out_ready;
   assign out_data    = r_h_data;
   assign out_exccode = r_h_exc;
   assign out_delay   = r_h_dly;
   assign out_exc     = out_valid && (r_h_exc != '0);

`ifdef PIPE_SKID_EN
   // Next state and entry routing; clear wins over any transfer.
   always_comb begin
      w_state  = r_state;
      w_h_data = r_h_data;
      w_h_exc  = r_h_exc;
      w_h_dly  = r_h_dly;
      w_s_data = r_s_data;
      w_s_exc  = r_s_exc;
      w_s_dly  = r_s_dly;
      if (clear) begin
         w_state  = EMPTY;
         w_h_data = '0;
         w_h_exc  = '0;
         w_h_dly  = 1'b0;
         w_s_data = '0;
         w_s_exc  = '0;
         w_s_dly  = 1'b0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_acc) begin
                  w_state  = ONE;
                  w_h_data = in_data;
                  w_h_exc  = in_exccode;
                  w_h_dly  = in_delay;
               end
            end
            ONE: begin
               if (w_acc && !w_con) begin
                  w_state  = FULL;
                  w_s_data = in_data;
                  w_s_exc  = in_exccode;
                  w_s_dly  = in_delay;
               end else if (w_acc) begin
                  w_h_data = in_data;
                  w_h_exc  = in_exccode;
                  w_h_dly  = in_delay;
               end else if (w_con) begin
                  w_state  = EMPTY;
                  w_h_data = '0;
                  w_h_exc  = '0;
                  w_h_dly  = 1'b0;
               end
            end
            FULL: begin
               if (w_con) begin
                  w_state  = ONE;
                  w_h_data = r_s_data;
                  w_h_exc  = r_s_exc;
                  w_h_dly  = r_s_dly;
                  w_s_data = '0;
                  w_s_exc  = '0;
                  w_s_dly  = 1'b0;
               end
            end
            default: begin
               w_state  = EMPTY;
               w_h_data = '0;
               w_h_exc  = '0;
               w_h_dly  = 1'b0;
               w_s_data = '0;
               w_s_exc  = '0;
               w_s_dly  = 1'b0;
            end
         endcase
      end
   end

   // Skid register holds the entry accepted while the head is stalled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s_data <= '0;
         r_s_exc  <= '0;
         r_s_dly  <= 1'b0;
      end else begin
         r_s_data <= w_s_data;
         r_s_exc  <= w_s_exc;
         r_s_dly  <= w_s_dly;
      end
   end
`else
   // Single slot: accept loads (or replaces) H, consume alone empties it.
   always_comb begin
      w_state  = r_state;
      w_h_data = r_h_data;
      w_h_exc  = r_h_exc;
      w_h_dly  = r_h_dly;
      if (clear) begin
         w_state  = EMPTY;
         w_h_data = '0;
         w_h_exc  = '0;
         w_h_dly  = 1'b0;
      end else if (w_acc) begin
         w_state  = ONE;
         w_h_data = in_data;
         w_h_exc  = in_exccode;
         w_h_dly  = in_delay;
      end else if (w_con) begin
         w_state  = EMPTY;
         w_h_data = '0;
         w_h_exc  = '0;
         w_h_dly  = 1'b0;
      end
   end
`endif

   // State and head register; head is zero whenever the block is empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= EMPTY;
         r_h_data <= '0;
         r_h_exc  <= '0;
         r_h_dly  <= 1'b0;
      end else begin
         r_state  <= w_state;
         r_h_data <= w_h_data;
         r_h_exc  <= w_h_exc;
         r_h_dly  <= w_h_dly;
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: vector table, directed corner cases, queue-model random run.
// Skid-only sequences are selected by PIPE_SKID_EN.
module tb_pipe_stage_buf;

   localparam int DATA_W = 134;
   localparam int EXC_W  = 5;
   localparam int W      = DATA_W;
`ifdef PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              clear;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [EXC_W-1:0]  in_exccode;
   logic              in_delay;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [EXC_W-1:0]  out_exccode;
   logic              out_delay;
   logic              out_exc;
   logic [1:0]        occupancy;

   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [EXC_W-1:0]  e;
      logic              dl;
   } ent_t;

   typedef struct {
      logic             iv;
      logic [31:0]      d;
      logic [EXC_W-1:0] e;
      logic             dl;
      logic             ordy;
      logic             clr;
      logic             ev;
      logic [31:0]      ed;
      logic [EXC_W-1:0] ee;
      logic             edl;
      logic [1:0]       eocc;
   } vec_t;

   ent_t q[$];
   vec_t tbl[11];
   int   n_chk  = 0;
   int   n_fail = 0;

   pipe_stage_buf #(.DATA_W(DATA_W), .EXC_W(EXC_W)) dut (
      .clk(clk), .reset(reset), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_exccode(in_exccode), .in_delay(in_delay),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_exccode(out_exccode), .out_delay(out_delay),
      .out_exc(out_exc), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   function automatic logic mdl_ready();
      if (SKID) return q.size() < 2;
      return (q.size() == 0) || out_ready;
   endfunction

   // Drive one cycle, check in_ready against the model, advance the model and clock.
   task automatic tick(input logic iv, input logic [W-1:0] d,
                       input logic [EXC_W-1:0] e, input logic dl,
                       input logic ordy, input logic clr);
      logic rdy;
      in_valid   = iv;
      in_data    = d;
      in_exccode = e;
      in_delay   = dl;
      out_ready  = ordy;
      clear      = clr;
      #1;
      rdy = mdl_ready();
      chk("in_ready", W'(in_ready), W'(rdy));
      if (clr) begin
         q.delete();
      end else begin
         if (ordy && q.size() > 0) void'(q.pop_front());
         if (iv && rdy) q.push_back({d, e, dl});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_mdl();
      ent_t h;
      h = (q.size() > 0) ? q[0] : '0;
      chk("m_valid", W'(out_valid), W'(q.size() > 0));
      chk("m_data", out_data, h.d);
      chk("m_exccode", W'(out_exccode), W'(h.e));
      chk("m_delay", W'(out_delay), W'(h.dl));
      chk("m_exc", W'(out_exc), W'(q.size() > 0 && h.e != 0));
      chk("m_occ", W'(occupancy), W'(q.size()));
   endtask

   task automatic chk_out(input string nm, input logic v,
                          input logic [W-1:0] d, input logic [1:0] occ);
      chk({nm, "_valid"}, W'(out_valid), W'(v));
      chk({nm, "_data"}, out_data, d);
      chk({nm, "_occ"}, W'(occupancy), W'(occ));
   endtask

   initial begin
      logic [159:0] rnd;
      tbl[0]  = '{1'b1, 32'h1234, 5'd0, 1'b0, 1'b1, 1'b0,
                  1'b1, 32'h1234, 5'd0, 1'b0, 2'd1};
      tbl[1]  = '{1'b1, 32'h5, 5'd4, 1'b1, 1'b1, 1'b0,
                  1'b1, 32'h5, 5'd4, 1'b1, 2'd1};
      tbl[2]  = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0,
                  1'b0, 32'h0, 5'd0, 1'b0, 2'd0};
      tbl[3]  = '{1'b1, 32'h7, 5'd0, 1'b0, 1'b0, 1'b0,
                  1'b1, 32'h7, 5'd0, 1'b0, 2'd1};
      tbl[4]  = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0,
                  1'b1, 32'h7, 5'd0, 1'b0, 2'd1};
      tbl[5]  = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0,
                  1'b0, 32'h0, 5'd0, 1'b0, 2'd0};
      tbl[6]  = '{1'b1, 32'h9, 5'd3, 1'b1, 1'b1, 1'b1,
                  1'b0, 32'h0, 5'd0, 1'b0, 2'd0};
      tbl[7]  = '{1'b1, 32'hA, 5'd0, 1'b0, 1'b1, 1'b0,
                  1'b1, 32'hA, 5'd0, 1'b0, 2'd1};
      tbl[8]  = '{1'b1, 32'hB, 5'd0, 1'b0, 1'b0, 1'b1,
                  1'b0, 32'h0, 5'd0, 1'b0, 2'd0};
      tbl[9]  = '{1'b1, 32'hC, 5'd2, 1'b0, 1'b1, 1'b0,
                  1'b1, 32'hC, 5'd2, 1'b0, 2'd1};
      tbl[10] = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0,
                  1'b0, 32'h0, 5'd0, 1'b0, 2'd0};

      reset      = 1'b0;
      clear      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      in_exccode = '0;
      in_delay   = 1'b0;
      out_ready  = 1'b0;
      #1;
      chk_out("rst", 1'b0, '0, 2'd0);
      chk("rst_exccode", W'(out_exccode), '0);
      chk("rst_delay", W'(out_delay), '0);
      chk("rst_exc", W'(out_exc), '0);
      chk("rst_in_ready", W'(in_ready), W'(1'b1));
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 11; i++) begin
         tick(tbl[i].iv, W'(tbl[i].d), tbl[i].e, tbl[i].dl,
              tbl[i].ordy, tbl[i].clr);
         chk_out($sformatf("vec%0d", i), tbl[i].ev, W'(tbl[i].ed),
                 tbl[i].eocc);
         chk($sformatf("vec%0d_exccode", i), W'(out_exccode), W'(tbl[i].ee));
         chk($sformatf("vec%0d_delay", i), W'(out_delay), W'(tbl[i].edl));
         chk($sformatf("vec%0d_exc", i), W'(out_exc),
             W'(tbl[i].ev && tbl[i].ee != 0));
      end

      for (int i = 1; i <= 8; i++) begin
         tick(1'b1, W'(i), '0, 1'b0, 1'b1, 1'b0);
         chk_out($sformatf("stream%0d", i), 1'b1, W'(i), 2'd1);
      end
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      chk_out("stream_end", 1'b0, '0, 2'd0);

`ifdef PIPE_SKID_EN
      tick(1'b1, W'(1), '0, 1'b0, 1'b0, 1'b0);
      chk_out("skid_a1", 1'b1, W'(1), 2'd1);
      tick(1'b1, W'(2), '0, 1'b0, 1'b0, 1'b0);
      chk_out("skid_a2", 1'b1, W'(1), 2'd2);
      chk("skid_a2_rdy", W'(in_ready), '0);
      tick(1'b1, W'(3), '0, 1'b0, 1'b0, 1'b0);
      chk_out("skid_a3", 1'b1, W'(1), 2'd2);
      tick(1'b1, W'(3), '0, 1'b0, 1'b1, 1'b0);
      chk_out("skid_d1", 1'b1, W'(2), 2'd1);
      tick(1'b1, W'(3), '0, 1'b0, 1'b1, 1'b0);
      chk_out("skid_d2", 1'b1, W'(3), 2'd1);
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      chk_out("skid_d3", 1'b0, '0, 2'd0);
      tick(1'b1, W'(1), '0, 1'b0, 1'b0, 1'b0);
      tick(1'b1, W'(2), '0, 1'b0, 1'b0, 1'b0);
      chk_out("skid_full", 1'b1, W'(1), 2'd2);
      tick(1'b1, W'(3), '0, 1'b0, 1'b0, 1'b1);
      chk_out("skid_clr", 1'b0, '0, 2'd0);
      chk("skid_clr_rdy", W'(in_ready), W'(1'b1));
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      chk_out("skid_clr2", 1'b0, '0, 2'd0);
`else
      tick(1'b1, W'(1), '0, 1'b0, 1'b0, 1'b0);
      chk_out("bp1", 1'b1, W'(1), 2'd1);
      chk("bp1_rdy", W'(in_ready), '0);
      tick(1'b1, W'(2), '0, 1'b0, 1'b0, 1'b0);
      chk_out("bp2", 1'b1, W'(1), 2'd1);
      tick(1'b1, W'(2), '0, 1'b0, 1'b1, 1'b0);
      chk_out("bp_repl", 1'b1, W'(2), 2'd1);
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      chk_out("bp_end", 1'b0, '0, 2'd0);
`endif

      tick(1'b1, W'(32'h11), 5'd7, 1'b1, 1'b0, 1'b0);
      tick(1'b1, W'(32'h22), '0, 1'b0, 1'b0, 1'b0);
      #3;
      reset = 1'b0;
      #1;
      q.delete();
      chk_out("arst", 1'b0, '0, 2'd0);
      chk("arst_exccode", W'(out_exccode), '0);
      chk("arst_delay", W'(out_delay), '0);
      chk("arst_exc", W'(out_exc), '0);
      chk("arst_rdy", W'(in_ready), W'(1'b1));
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      tick(1'b1, W'(32'h33), '0, 1'b0, 1'b1, 1'b0);
      chk_out("post_rst", 1'b1, W'(32'h33), 2'd1);

      for (int i = 0; i < 600; i++) begin
         rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
         tick($urandom_range(0, 3) != 0, rnd[W-1:0],
              ($urandom_range(0, 3) == 0) ? EXC_W'($urandom) : '0,
              1'($urandom), $urandom_range(0, 2) != 0,
              $urandom_range(0, 31) == 0);
         chk_mdl();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage register with a ready/valid handshake, synchronous flush and an exception sideband. It generalises the fixed EX/MEM latch into one reusable block for every inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) of the P7 MIPS pipeline. A stall on either side is absorbed by backpressure instead of a global freeze. An optional skid buffer breaks the combinational ready path between stages.

## Interface
Parameters:
- DATA_W, 134, payload width; the EX/MEM default packs ALUout, din, IR, PC (4×32), WA (5) and cgcp0 (1).
- EXC_W, 5, exception-code width; code 0 means no exception.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; discards all held entries.
- in_valid  input  1  upstream holds a valid entry.
- in_ready  output  1  block accepts an entry this cycle.
- in_data  input  DATA_W  payload.
- in_exccode  input  EXC_W  exception code raised upstream.
- in_delay  input  1  entry is in a branch delay slot.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes the head entry this cycle.
- out_data  output  DATA_W  head payload.
- out_exccode  output  EXC_W  head exception code.
- out_delay  output  1  head delay-slot flag.
- out_exc  output  1  equals out_valid && (out_exccode != 0).
- occupancy  output  2  number of held entries (0–2).

## Operation
- Accept: in_valid && in_ready at an edge.
- Consume: out_valid && out_ready at an edge.
- Payload, exccode and delay move together as one entry and are never split or reordered. Order is FIFO.
- Storage: head register H, plus skid register S when PIPE_SKID_EN is defined.
- States (skid build):
  - EMPTY: occupancy 0.
  - ONE: H valid.
  - FULL: H and S valid.
- Transitions (skid build):
  - EMPTY: accept → ONE.
  - ONE: accept without consume → FULL, entry goes to S. Accept with consume → ONE, new entry goes to H. Consume only → EMPTY.
  - FULL: consume → ONE, S moves to H. Accept is impossible because in_ready is 0.
- in_ready (skid build) = !S_valid. It is a registered signal with no combinational path from out_ready.
- Non-skid build:
  - Only H exists. States are EMPTY and ONE.
  - in_ready = !H_valid || out_ready (combinational).
  - Simultaneous accept and consume replaces H.
- clear:
  - Priority over accept and consume in the same cycle.
  - The next state is EMPTY, and the data, exccode and delay registers are zeroed.
  - An entry offered during a clear cycle is dropped, even if in_ready was 1.
- Output registers are zero whenever out_valid = 0. A bubble never shows stale data. Downstream hazard logic relies on this (IR = 0 is a nop, WA = 0).
- The block does not alter the exception code; it only qualifies it with valid.

## Timing
- Reset (reset low, asynchronous):
  - out_valid = 0, out_data = 0, out_exccode = 0, out_delay = 0, out_exc = 0, occupancy = 0.
  - in_ready = 1 in both builds.
- Latency: an entry accepted at edge N appears on out_* after edge N (one cycle). There is no combinational in→out path.
- Throughput: one entry per cycle while out_ready is held 1, in both builds.
- Backpressure (skid build): after out_ready drops, in_ready drops at most one edge later. The entry accepted in that cycle lands in S and is not lost.
- Reset asserted mid-transfer loses all entries. The first accept after release is possible in the cycle after reset deasserts.

## Configuration
- PIPE_SKID_EN:
  - Defined: 2-entry skid storage, registered in_ready, occupancy range 0–2.
  - Undefined: single register with combinational in_ready. occupancy[1] is tied to 0. No S register is synthesised.

## Test plan
- Reset release, in_valid = 1, in_data = 0x…1234, out_ready = 1 → out_valid = 1 with data 0x…1234 one cycle later; occupancy = 1.
- Streaming of 8 entries with values 1..8, out_ready = 1 throughout → outputs 1..8 on consecutive cycles with no gaps, in order.
- Skid build: out_ready = 0 while streaming 1,2,3 → H = 1, S = 2, in_ready = 0, entry 3 held upstream. Then out_ready = 1 → outputs 1,2,3 in order; occupancy goes 2→1→1→0.
- clear asserted in the same cycle as an accept while occupancy = 2 → next cycle out_valid = 0, out_data = 0, occupancy = 0, and the offered entry is never output.
- in_exccode = 5'd4, in_delay = 1 → out_exccode = 4, out_delay = 1, out_exc = 1. In the following bubble cycle, out_exc = 0 and out_exccode = 0.
- reset driven low asynchronously between edges while FULL → outputs go to their reset values immediately, without waiting for a clock edge.
